// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared types and constants for the dual-port synchronous RAM.
//   collision_mode_e : behaviour of a cross-port read/write at one address
//   init_state_e     : clear engine state (INIT clears the array, RUN serves)
//   MAX_READ_LATENCY : deepest supported read pipeline
//   BYTE             : byte-lane width used by the byte enables
// ---------------------------------------------------------------------------
package ram_pkg;

    typedef enum logic {
        READ_OLD = 1'b0,
        READ_NEW = 1'b1
    } collision_mode_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } init_state_e;

    localparam int MAX_READ_LATENCY = 3;
    localparam int BYTE             = 8;

    function automatic bit latency_ok(input int latency);
        return (latency >= 1) && (latency <= MAX_READ_LATENCY);
    endfunction

endpackage

// File: rtl/dual_port_sync_ram_rd_pipe.sv
// ---------------------------------------------------------------------------
// ram_rd_pipe
// Read-return pipeline for one RAM port. Stage 0 captures the array word on
// the cycle the read is accepted; READ_LATENCY-1 further stages delay it.
// Data registers only load alongside a valid, so rdata holds the last
// returned word while rvalid is low.
//   clk, rst_n : clock, synchronous active-low reset (flushes all stages)
//   rd_en      : read accepted this cycle
//   rd_word    : word to return (array contents, already bypass-merged)
//   rvalid     : read data valid, one cycle per accepted read
//   rdata      : read data
// ---------------------------------------------------------------------------
module ram_rd_pipe
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_word,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata
);

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("ram_rd_pipe: READ_LATENCY %0d outside 1..%0d", READ_LATENCY, MAX_READ_LATENCY);
    end

    logic                  vld_p  [READ_LATENCY];
    logic [DATA_WIDTH-1:0] data_p [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_p[i]  <= 1'b0;
                data_p[i] <= '0;
            end
        end else begin
            // stage 0: array read register
            vld_p[0] <= rd_en;
            if (rd_en) begin
                data_p[0] <= rd_word;
            end
            // stages 1..READ_LATENCY-1: delay line
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                if (vld_p[i-1]) begin
                    data_p[i] <= data_p[i-1];
                end
            end
        end
    end

    assign rvalid = vld_p[READ_LATENCY-1];
    assign rdata  = data_p[READ_LATENCY-1];

endmodule

// File: rtl/dual_port_sync_ram.sv
// ---------------------------------------------------------------------------
// dual_port_sync_ram
// True dual-port synchronous RAM with byte enables, a 1..3 cycle read
// pipeline per port, defined same-address collision behaviour and an
// optional clear-after-reset engine.
//   clk, rst_n         : clock, synchronous active-low reset
//   ready              : both ports accept requests (low in reset and while clearing)
//   a_req / b_req      : request this cycle
//   a_we / b_we        : 1 = write, 0 = read
//   a_addr / b_addr    : word address
//   a_wdata / b_wdata  : write data
//   a_be / b_be        : byte enables for writes
//   a_rvalid / b_rvalid: read data valid
//   a_rdata / b_rdata  : read data
// ---------------------------------------------------------------------------
module dual_port_sync_ram
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 16,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int READ_LATENCY   = 1,
    parameter int COLLISION_MODE = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ready,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic [BE_WIDTH-1:0]   a_be,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    input  logic [BE_WIDTH-1:0]   b_be,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    localparam int                    LENGTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam bit                    BYPASS    = (COLLISION_MODE == int'(READ_NEW));

    if (DATA_WIDTH % BYTE != 0) begin : g_bad_width
        $error("dual_port_sync_ram: DATA_WIDTH %0d is not a multiple of 8", DATA_WIDTH);
    end
    if (BE_WIDTH != DATA_WIDTH / BYTE) begin : g_bad_be
        $error("dual_port_sync_ram: BE_WIDTH must equal DATA_WIDTH/8");
    end
    if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("dual_port_sync_ram: READ_LATENCY %0d outside 1..%0d", READ_LATENCY, MAX_READ_LATENCY);
    end
    if (COLLISION_MODE != 0 && COLLISION_MODE != 1) begin : g_bad_mode
        $error("dual_port_sync_ram: COLLISION_MODE must be 0 or 1");
    end

    // Replace the bytes of old_word that the other port is writing this cycle.
    function automatic logic [DATA_WIDTH-1:0] bypass_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_WIDTH-1:0]   be,
        input logic                  hit
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (hit && be[i]) begin
                merged[i*BYTE +: BYTE] = new_word[i*BYTE +: BYTE];
            end
        end
        return merged;
    endfunction

    logic [DATA_WIDTH-1:0] mem [LENGTH];

    init_state_e           state, state_next;
    logic [ADDR_WIDTH-1:0] clr_addr, clr_addr_next;
    logic                  clr_we;

    logic                  a_rd, a_wr, b_rd, b_wr;
    logic [DATA_WIDTH-1:0] a_word, b_word;

    // ---------------- clear engine ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= INIT;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        clr_we        = 1'b0;
        unique case (state)
            INIT: begin
                if (CLEAR_ON_RESET != 0) begin
                    // rst_n gate keeps reset itself from touching the array
                    clr_we        = rst_n;
                    clr_addr_next = clr_addr + ADDR_WIDTH'(1);
                    if (clr_addr == LAST_ADDR) begin
                        state_next = RUN;
                    end
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
        endcase
    end

    // ready drops combinationally with rst_n so nothing is accepted in reset
    assign ready = rst_n && (state == RUN);

    assign a_rd = a_req && ready && !a_we;
    assign a_wr = a_req && ready &&  a_we;
    assign b_rd = b_req && ready && !b_we;
    assign b_wr = b_req && ready &&  b_we;

    // ---------------- array write ----------------
    // B lanes are assigned first so A wins any lane both ports enable.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (b_wr && b_be[i]) begin
                    mem[b_addr][i*BYTE +: BYTE] <= b_wdata[i*BYTE +: BYTE];
                end
            end
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (a_wr && a_be[i]) begin
                    mem[a_addr][i*BYTE +: BYTE] <= a_wdata[i*BYTE +: BYTE];
                end
            end
        end
    end

    // ---------------- read word select ----------------
    // READ_OLD: the array read sees the pre-write word at the same edge.
    // READ_NEW: bytes the other port writes this cycle are forwarded.
    always_comb begin
        a_word = mem[a_addr];
        b_word = mem[b_addr];
        if (BYPASS) begin
            a_word = bypass_merge(mem[a_addr], b_wdata, b_be, b_wr && (b_addr == a_addr));
            b_word = bypass_merge(mem[b_addr], a_wdata, a_be, a_wr && (a_addr == b_addr));
        end
    end

    // ---------------- read pipelines ----------------
    ram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_a_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (a_rd),
        .rd_word (a_word),
        .rvalid  (a_rvalid),
        .rdata   (a_rdata)
    );

    ram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_b_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (b_rd),
        .rd_word (b_word),
        .rvalid  (b_rvalid),
        .rdata   (b_rdata)
    );

endmodule

// File: tb/tb_dual_port_sync_ram.sv
// ---------------------------------------------------------------------------
// tb_dual_port_sync_ram
// Directed bench. Two RAMs share all inputs:
//   u0 : READ_LATENCY=3, READ_OLD collisions
//   u1 : READ_LATENCY=1, READ_NEW collisions
// Both use ADDR_WIDTH=4, DATA_WIDTH=16, CLEAR_ON_RESET=1.
// ---------------------------------------------------------------------------
module tb_dual_port_sync_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [3:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic [1:0]  a_be, b_be;

    logic        ready0, a_rvalid0, b_rvalid0;
    logic [15:0] a_rdata0, b_rdata0;
    logic        ready1, a_rvalid1, b_rvalid1;
    logic [15:0] a_rdata1, b_rdata1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] sw [4];

    always #5 clk = ~clk;

    dual_port_sync_ram #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .READ_LATENCY(3),
        .COLLISION_MODE(0), .CLEAR_ON_RESET(1)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .ready(ready0),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
        .a_rvalid(a_rvalid0), .a_rdata(a_rdata0),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
        .b_rvalid(b_rvalid0), .b_rdata(b_rdata0)
    );

    dual_port_sync_ram #(
        .ADDR_WIDTH(4), .DATA_WIDTH(16), .READ_LATENCY(1),
        .COLLISION_MODE(1), .CLEAR_ON_RESET(1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .ready(ready1),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
        .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
        .b_rvalid(b_rvalid1), .b_rdata(b_rdata1)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [3:0] addr,
                           input logic [15:0] wd, input logic [1:0] be);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wd; a_be = be;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [3:0] addr,
                           input logic [15:0] wd, input logic [1:0] be);
        b_req = req; b_we = we; b_addr = addr; b_wdata = wd; b_be = be;
    endtask

    task automatic idle();
        drive_a(1'b0, 1'b0, 4'd0, 16'h0000, 2'b00);
        drive_b(1'b0, 1'b0, 4'd0, 16'h0000, 2'b00);
    endtask

    // Issue reads (plus whatever the caller already drove on the other port),
    // then check u1 one cycle later and u0 three cycles later.
    task automatic rd(input bit use_a, input bit use_b,
                      input logic [3:0] addr_a, input logic [3:0] addr_b,
                      input logic [15:0] ea0, input logic [15:0] ea1,
                      input logic [15:0] eb0, input logic [15:0] eb1,
                      input string tag);
        if (use_a) drive_a(1'b1, 1'b0, addr_a, 16'h0000, 2'b00);
        if (use_b) drive_b(1'b1, 1'b0, addr_b, 16'h0000, 2'b00);
        step();
        idle();
        check({tag, "/a1_vld"}, 16'(a_rvalid1), 16'(use_a));
        check({tag, "/b1_vld"}, 16'(b_rvalid1), 16'(use_b));
        if (use_a) check({tag, "/a1_data"}, a_rdata1, ea1);
        if (use_b) check({tag, "/b1_data"}, b_rdata1, eb1);
        check({tag, "/a0_early"}, 16'(a_rvalid0), 16'h0);
        step();
        step();
        check({tag, "/a0_vld"}, 16'(a_rvalid0), 16'(use_a));
        check({tag, "/b0_vld"}, 16'(b_rvalid0), 16'(use_b));
        if (use_a) check({tag, "/a0_data"}, a_rdata0, ea0);
        if (use_b) check({tag, "/b0_data"}, b_rdata0, eb0);
        check({tag, "/a1_drop"}, 16'(a_rvalid1), 16'h0);
        if (use_a) check({tag, "/a1_hold"}, a_rdata1, ea1);
    endtask

    // Called at a negedge just after rst_n was raised. Holds requests that
    // must be ignored while clearing and counts cycles until ready.
    task automatic wait_ready(input string tag);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        drive_a(1'b1, 1'b0, 4'd5, 16'h0000, 2'b00);
        drive_b(1'b1, 1'b0, 4'd6, 16'h0000, 2'b00);
        while (cyc < 40) begin
            step();
            cyc++;
            if (a_rvalid0 || a_rvalid1 || b_rvalid0 || b_rvalid1) seen = 1'b1;
            if (ready0) break;
        end
        idle();
        check({tag, "/ready_cycles"}, 16'(cyc), 16'd16);
        check({tag, "/ready1"}, 16'(ready1), 16'h1);
        check({tag, "/ignored_rd"}, 16'(seen), 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sw[0] = 16'hC000; sw[1] = 16'hC101; sw[2] = 16'hC202; sw[3] = 16'hC303;
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        step(); step(); step();

        // reset state
        check("rst/ready0", 16'(ready0), 16'h0);
        check("rst/ready1", 16'(ready1), 16'h0);
        check("rst/a_vld0", 16'(a_rvalid0), 16'h0);
        check("rst/a_data0", a_rdata0, 16'h0000);
        check("rst/b_data1", b_rdata1, 16'h0000);

        // 1. clear and readback
        rst_n = 1'b1;
        wait_ready("clr1");
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) rd(1'b1, 1'b0, 4'(i), 4'd0, 16'h0, 16'h0, 16'h0, 16'h0, "clr_rd_a");
            else            rd(1'b0, 1'b1, 4'd0, 4'(i), 16'h0, 16'h0, 16'h0, 16'h0, "clr_rd_b");
        end

        // 2. byte-enable writes, be=0 no-op, dual read of one address
        drive_a(1'b1, 1'b1, 4'd3, 16'hBEEF, 2'b11); step();
        drive_a(1'b1, 1'b1, 4'd3, 16'h1234, 2'b10); step();
        idle();
        rd(1'b1, 1'b0, 4'd3, 4'd0, 16'h12EF, 16'h12EF, 16'h0, 16'h0, "be_wr");
        drive_a(1'b1, 1'b1, 4'd3, 16'hFFFF, 2'b00); step();
        idle();
        rd(1'b1, 1'b1, 4'd3, 4'd3, 16'h12EF, 16'h12EF, 16'h12EF, 16'h12EF, "be0_dual");

        // 3. streaming reads
        drive_a(1'b1, 1'b1, 4'd0, sw[0], 2'b11);
        drive_b(1'b1, 1'b1, 4'd1, sw[1], 2'b11); step();
        drive_a(1'b1, 1'b1, 4'd2, sw[2], 2'b11);
        drive_b(1'b1, 1'b1, 4'd3, sw[3], 2'b11); step();
        idle();
        drive_a(1'b1, 1'b0, 4'd0, 16'h0, 2'b00);
        for (int j = 0; j < 7; j++) begin
            step();
            check("strm/a0_vld", 16'(a_rvalid0), 16'((j >= 2) && (j <= 5)));
            if (j >= 2 && j <= 5) check("strm/a0_data", a_rdata0, sw[j-2]);
            check("strm/a1_vld", 16'(a_rvalid1), 16'(j <= 3));
            if (j <= 3) check("strm/a1_data", a_rdata1, sw[j]);
            if (j + 1 < 4) drive_a(1'b1, 1'b0, 4'(j + 1), 16'h0, 2'b00);
            else           idle();
        end

        // 4. write/write collision
        drive_a(1'b1, 1'b1, 4'd9, 16'hAAAA, 2'b01);
        drive_b(1'b1, 1'b1, 4'd9, 16'h5555, 2'b11); step();
        idle();
        rd(1'b1, 1'b0, 4'd9, 4'd0, 16'h55AA, 16'h55AA, 16'h0, 16'h0, "ww_coll");

        // 5. read/write collision, both directions
        drive_a(1'b1, 1'b1, 4'd7, 16'h1111, 2'b11); step();
        idle();
        drive_b(1'b1, 1'b1, 4'd7, 16'h2222, 2'b11);
        rd(1'b1, 1'b0, 4'd7, 4'd0, 16'h1111, 16'h2222, 16'h0, 16'h0, "rw_coll_a");
        rd(1'b0, 1'b1, 4'd0, 4'd7, 16'h0, 16'h0, 16'h2222, 16'h2222, "rw_after");
        drive_a(1'b1, 1'b1, 4'd7, 16'h3344, 2'b01);
        rd(1'b0, 1'b1, 4'd0, 4'd7, 16'h0, 16'h0, 16'h2222, 16'h2244, "rw_coll_b");
        rd(1'b1, 1'b0, 4'd7, 4'd0, 16'h2244, 16'h2244, 16'h0, 16'h0, "rw_after2");

        // 6a. reset with reads in flight
        drive_a(1'b1, 1'b0, 4'd3, 16'h0, 2'b00); step();
        drive_a(1'b1, 1'b0, 4'd9, 16'h0, 2'b00); step();
        rst_n = 1'b0;
        idle();
        step();
        check("rst_fly/a0_vld", 16'(a_rvalid0), 16'h0);
        check("rst_fly/a0_data", a_rdata0, 16'h0000);
        check("rst_fly/a1_vld", 16'(a_rvalid1), 16'h0);
        check("rst_fly/a1_data", a_rdata1, 16'h0000);
        step();
        check("rst_fly/a0_vld2", 16'(a_rvalid0), 16'h0);

        // 6b. reset during clear at address 5
        rst_n = 1'b1;
        repeat (5) step();
        check("rst_init/ready_mid", 16'(ready0), 16'h0);
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        wait_ready("clr2");
        rd(1'b1, 1'b1, 4'd3, 4'd9, 16'h0, 16'h0, 16'h0, 16'h0, "clr2_rd");
        rd(1'b1, 1'b0, 4'd15, 4'd0, 16'h0, 16'h0, 16'h0, 16'h0, "clr2_last");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
